// File: rtl/bin_to_bcd_display_pkg.sv
// Shared definitions for the binary-to-BCD display front end.
// State encoding, BCD limits and the overflow pattern.
package bin_to_bcd_display_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StConv = 1'b1
  } state_e;

  localparam int unsigned BCD_MAX     = 9999;
  localparam logic [15:0] OVF_PATTERN = 16'hEEEE;
  localparam int unsigned BCD_DIGITS  = 4;

endpackage

// File: rtl/bin_to_bcd_display_if.sv
// Handshake and display-side signals between the datapath, the converter and the scanner.
// The master drives the binary value; the slave (converter) drives the BCD result.
interface bin_to_bcd_display_if #(
  parameter int unsigned IN_WIDTH = 16
);

  logic                in_valid;
  logic                in_ready;
  logic [IN_WIDTH-1:0] in_bin;
  logic [15:0]         bcd_out;
  logic                out_valid;
  logic                ovf;
  logic                busy;

  modport master (
    output in_valid,
    output in_bin,
    input  in_ready,
    input  bcd_out,
    input  out_valid,
    input  ovf,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_bin,
    output in_ready,
    output bcd_out,
    output out_valid,
    output ovf,
    output busy
  );

endinterface

// File: rtl/bcd_digit_adj3.sv
// Combinational shift-and-add-3 correction for one BCD digit.
// Adds 3 to digits of 5 or more; the carry out of the nibble is dropped.
module bcd_digit_adj3 (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_display.sv
// Sequential binary-to-BCD converter, one input bit per cycle, holding a packed
// 4-digit BCD word for the display scanner; values above 9999 show as EEEE.
module bin_to_bcd_display
  import bin_to_bcd_display_pkg::*;
#(
  parameter int unsigned IN_WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  bin_to_bcd_display_if.slave  bus
);

  localparam int unsigned CntW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;

  state_e              state_q;
  logic [IN_WIDTH-1:0] bin_sr_q;
  logic [15:0]         scratch_q;
  logic [CntW-1:0]     cnt_q;
  logic                ovf_pend_q;
  logic [15:0]         bcd_q;
  logic                ovf_q;
  logic                out_valid_q;

  logic [15:0]         adj;
  logic [15:0]         scratch_d;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_digit_adj3 u_adj (
      .digit_i (scratch_q[4*g +: 4]),
      .digit_o (adj[4*g +: 4])
    );
  end

  // Top bit of the corrected scratch falls off; input MSB enters at bit 0.
  assign scratch_d = (adj << 1) | 16'(bin_sr_q[IN_WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bin_sr_q    <= '0;
      scratch_q   <= '0;
      cnt_q       <= '0;
      ovf_pend_q  <= 1'b0;
      bcd_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            bin_sr_q   <= bus.in_bin;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= (32'(bus.in_bin) > BCD_MAX);
            state_q    <= StConv;
          end
        end
        StConv: begin
          cnt_q    <= cnt_q + CntW'(1);
          bin_sr_q <= bin_sr_q << 1;
          // Last step lands straight in the output so the display never sees scratch.
          if (cnt_q == CntW'(IN_WIDTH - 1)) begin
            bcd_q       <= ovf_pend_q ? OVF_PATTERN : scratch_d;
            ovf_q       <= ovf_pend_q;
            out_valid_q <= 1'b1;
            state_q     <= StIdle;
          end else begin
            scratch_q <= scratch_d;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.busy      = (state_q == StConv);
  assign bus.bcd_out   = bcd_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_bin_to_bcd_display.sv
// Directed self-checking bench for bin_to_bcd_display (IN_WIDTH = 16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bin_to_bcd_display;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  bin_to_bcd_display_if #(.IN_WIDTH(16)) bus ();

  bin_to_bcd_display #(.IN_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One-cycle request; returns at the falling edge after the acceptance edge.
  task automatic accept(input logic [15:0] v);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_bin   = v;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Counts falling edges until out_valid is seen; 40 means it never came.
  task automatic wait_done(output int n);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.bcd_out !== 16'h0000) begin bad++; $display("FAIL reset_bcd: got %h want 0000", bus.bcd_out); end
    total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_single();
    int n;
    int busy_cnt;
    logic [15:0] held;
    held = bus.bcd_out;
    accept(16'd1234);
    n = 0;
    busy_cnt = 0;
    while (!bus.out_valid && n < 40) begin
      if (bus.busy) busy_cnt++;
      total++;
      if (bus.bcd_out !== held) begin
        bad++; $display("FAIL single_hold: got %h want %h", bus.bcd_out, held);
      end
      @(negedge clk);
      n++;
    end
    total++; if (n !== 16) begin bad++; $display("FAIL single_latency: got %0d want 16", n); end
    total++; if (busy_cnt !== 16) begin bad++; $display("FAIL single_busy_cycles: got %0d want 16", busy_cnt); end
    total++; if (bus.bcd_out !== 16'h1234) begin bad++; $display("FAIL single_bcd: got %h want 1234", bus.bcd_out); end
    total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL single_ovf: got %b want 0", bus.ovf); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL single_ready: got %b want 1", bus.in_ready); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_busy_end: got %b want 0", bus.busy); end
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_pulse_width: got %b want 0", bus.out_valid); end
    total++; if (bus.bcd_out !== 16'h1234) begin bad++; $display("FAIL single_bcd_held: got %h want 1234", bus.bcd_out); end
  endtask

  task automatic test_boundaries();
    logic [15:0] vals [5];
    logic [15:0] exps [5];
    logic        ovfs [5];
    int n;
    vals = '{16'd0, 16'd9999, 16'd10000, 16'd65535, 16'd42};
    exps = '{16'h0000, 16'h9999, 16'hEEEE, 16'hEEEE, 16'h0042};
    ovfs = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      accept(vals[i]);
      wait_done(n);
      total++; if (n !== 16) begin bad++; $display("FAIL bound_latency[%0d]: got %0d want 16", vals[i], n); end
      total++; if (bus.bcd_out !== exps[i]) begin bad++; $display("FAIL bound_bcd[%0d]: got %h want %h", vals[i], bus.bcd_out, exps[i]); end
      total++; if (bus.ovf !== ovfs[i]) begin bad++; $display("FAIL bound_ovf[%0d]: got %b want %b", vals[i], bus.ovf, ovfs[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int n2;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_bin   = 16'd7;
    @(negedge clk);
    wait_done(n);
    total++; if (n !== 16) begin bad++; $display("FAIL b2b_first_latency: got %0d want 16", n); end
    total++; if (bus.bcd_out !== 16'h0007) begin bad++; $display("FAIL b2b_first_bcd: got %h want 0007", bus.bcd_out); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_at_pulse: got %b want 1", bus.in_ready); end
    bus.in_bin = 16'd805;
    @(negedge clk);
    bus.in_valid = 1'b0;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_second_accepted: busy got %b want 1", bus.busy); end
    wait_done(n2);
    total++; if (n2 + 1 !== 17) begin bad++; $display("FAIL b2b_pulse_spacing: got %0d want 17", n2 + 1); end
    total++; if (bus.bcd_out !== 16'h0805) begin bad++; $display("FAIL b2b_second_bcd: got %h want 0805", bus.bcd_out); end
  endtask

  task automatic test_disturb();
    int n;
    int extra;
    accept(16'd4321);
    bus.in_bin = 16'd9;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = ~bus.in_valid;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    wait_done(n);
    total++; if (n + 10 !== 16) begin bad++; $display("FAIL disturb_latency: got %0d want 16", n + 10); end
    total++; if (bus.bcd_out !== 16'h4321) begin bad++; $display("FAIL disturb_bcd: got %h want 4321", bus.bcd_out); end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid || bus.busy) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL disturb_single_accept: got %0d extra active cycles want 0", extra); end
  endtask

  task automatic test_reset_mid();
    int n;
    int pulses;
    int changed;
    accept(16'd10000);
    wait_done(n);
    total++; if (bus.ovf !== 1'b1) begin bad++; $display("FAIL midrst_pre_ovf: got %b want 1", bus.ovf); end
    accept(16'd5678);
    repeat (7) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.bcd_out !== 16'h0000) begin bad++; $display("FAIL midrst_bcd: got %h want 0000", bus.bcd_out); end
    total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL midrst_ovf: got %b want 0", bus.ovf); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %b want 1", bus.in_ready); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    changed = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.out_valid) pulses++;
      if (bus.bcd_out !== 16'h0000) changed++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL midrst_no_pulse: got %0d pulses want 0", pulses); end
    total++; if (changed !== 0) begin bad++; $display("FAIL midrst_bcd_held: got %0d nonzero cycles want 0", changed); end
    accept(16'd99);
    wait_done(n);
    total++; if (bus.bcd_out !== 16'h0099) begin bad++; $display("FAIL midrst_after_bcd: got %h want 0099", bus.bcd_out); end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_bin   = '0;
    test_reset();
    test_single();
    test_boundaries();
    test_back_to_back();
    test_disturb();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
